// File: rtl/enemy_shot_launcher_if.sv
// Enemy shot launcher bus: frame timing, enemy position and hit in,
// shot position and launch strobe out.
interface enemy_shot_launcher_if;
  logic        startOfFrame;
  logic        pause;
  logic [10:0] enemyTopLeftX;
  logic [10:0] enemyTopLeftY;
  logic        shotHitTarget;
  logic [10:0] shotTopLeftX;
  logic [10:0] shotTopLeftY;
  logic        shotActive;
  logic        fireStrobe;

  modport master (
    output startOfFrame,
    output pause,
    output enemyTopLeftX,
    output enemyTopLeftY,
    output shotHitTarget,
    input  shotTopLeftX,
    input  shotTopLeftY,
    input  shotActive,
    input  fireStrobe
  );

  modport slave (
    input  startOfFrame,
    input  pause,
    input  enemyTopLeftX,
    input  enemyTopLeftY,
    input  shotHitTarget,
    output shotTopLeftX,
    output shotTopLeftY,
    output shotActive,
    output fireStrobe
  );
endinterface

// File: rtl/enemy_shot_launcher.sv
// Enemy shot launcher: cooldown, arm, launch from enemy position,
// fall once per frame in x64 fixed point, retire at bottom or on hit.
module enemy_shot_launcher #(
  parameter int FIRE_PERIOD = 90,
  parameter int SHOT_SPEED  = 256,
  parameter int OFFSET_X    = 14,
  parameter int OFFSET_Y    = 32,
  parameter int BOTTOM_EDGE = 460,
  parameter int PARKED_X    = 700,
  parameter int FIXED_POINT_MULTIPLIER = 64
) (
  input logic clk,
  input logic reset,
  enemy_shot_launcher_if.slave bus
);

  localparam logic [1:0] COOLDOWN = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] FLYING   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [10:0] x_q, x_d;
  int          y_q, y_d;
  logic        stb_q, stb_d;

  logic        frame_go;
  logic [11:0] x_sum;
  logic [10:0] x_sat;
  int          y_launch;
  int          y_step;

  assign frame_go = bus.startOfFrame && !bus.pause;

  // X launch position, saturated so a live shot never reads as 7FF.
  assign x_sum = {1'b0, bus.enemyTopLeftX} + 12'(OFFSET_X);
  assign x_sat = (x_sum >= 12'h7FF) ? 11'h7FE : x_sum[10:0];

  assign y_launch = (int'({21'd0, bus.enemyTopLeftY}) + OFFSET_Y)
                    * FIXED_POINT_MULTIPLIER;
  assign y_step   = y_q + SHOT_SPEED;

  // Next-state logic; a hit outranks motion and the bottom edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    stb_d   = 1'b0;
    unique case (state_q)
      COOLDOWN: begin
        if (frame_go) begin
          if (cnt_q == 7'd0) state_d = ARMED;
          else cnt_d = cnt_q - 7'd1;
        end
      end
      ARMED: begin
        if (frame_go &&
            (int'({21'd0, bus.enemyTopLeftX}) < PARKED_X)) begin
          x_d     = x_sat;
          y_d     = y_launch;
          state_d = FLYING;
          stb_d   = 1'b1;
        end
      end
      FLYING: begin
        if (bus.shotHitTarget) begin
          state_d = COOLDOWN;
          cnt_d   = 7'(FIRE_PERIOD);
        end else if (frame_go) begin
          y_d = y_step;
          if ((y_step / FIXED_POINT_MULTIPLIER) > BOTTOM_EDGE) begin
            state_d = COOLDOWN;
            cnt_d   = 7'(FIRE_PERIOD);
          end
        end
      end
      default: begin
        state_d = COOLDOWN;
        cnt_d   = 7'(FIRE_PERIOD);
      end
    endcase
  end

  // State registers; reset discards any shot in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COOLDOWN;
      cnt_q   <= 7'(FIRE_PERIOD);
      x_q     <= 11'h7FF;
      y_q     <= 0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.shotActive   = (state_q == FLYING);
  assign bus.fireStrobe   = stb_q;
  assign bus.shotTopLeftX = (state_q == FLYING) ? x_q : 11'h7FF;
  assign bus.shotTopLeftY = (state_q == FLYING)
                            ? 11'(y_q / FIXED_POINT_MULTIPLIER)
                            : 11'h7FF;

endmodule

// File: tb/tb_enemy_shot_launcher.sv
// Bench for enemy_shot_launcher: table of frame steps with
// hand-derived expectations, checked through a scoreboard queue.
module tb_enemy_shot_launcher;

  typedef struct {
    int   rep;
    logic sof, pse, hit;
    int   ex, ey;
    logic act, stb;
    int   x, y, dy;
  } row_t;

  typedef struct {
    logic        act, stb;
    logic [10:0] x, y;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  row_t tbl[$];
  row_t tbl2[$];
  exp_t sb[$];

  enemy_shot_launcher_if bus ();

  enemy_shot_launcher dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t r(
    int rep, logic sof, logic pse, logic hit,
    int ex, int ey,
    logic act, logic stb, int x, int y, int dy
  );
    row_t t;
    t.rep = rep; t.sof = sof; t.pse = pse; t.hit = hit;
    t.ex = ex; t.ey = ey;
    t.act = act; t.stb = stb;
    t.x = x; t.y = y; t.dy = dy;
    return t;
  endfunction

  function automatic row_t idle(
    int rep, logic sof, logic pse, logic hit, int ex, int ey
  );
    return r(rep, sof, pse, hit, ex, ey, 1'b0, 1'b0, 2047, 2047, 0);
  endfunction

  task automatic push_exp(logic act, logic stb, int x, int y);
    exp_t e;
    e.act = act; e.stb = stb;
    e.x = 11'(x); e.y = 11'(y);
    sb.push_back(e);
  endtask

  task automatic check(string nm, int idx);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s.%0d: scoreboard empty", nm, idx);
    end else begin
      e = sb.pop_front();
      if (bus.shotActive !== e.act || bus.fireStrobe !== e.stb ||
          bus.shotTopLeftX !== e.x || bus.shotTopLeftY !== e.y) begin
        n_err++;
        $display("FAIL %s.%0d: got act=%b stb=%b x=%0d y=%0d want act=%b stb=%b x=%0d y=%0d",
                 nm, idx, bus.shotActive, bus.fireStrobe,
                 bus.shotTopLeftX, bus.shotTopLeftY,
                 e.act, e.stb, e.x, e.y);
      end
    end
  endtask

  task automatic run(string nm, input row_t t[$]);
    for (int i = 0; i < t.size(); i++) begin
      for (int k = 0; k < t[i].rep; k++) begin
        push_exp(t[i].act, t[i].stb, t[i].x, t[i].y + k * t[i].dy);
        bus.startOfFrame  = t[i].sof;
        bus.pause         = t[i].pse;
        bus.shotHitTarget = t[i].hit;
        bus.enemyTopLeftX = 11'(t[i].ex);
        bus.enemyTopLeftY = 11'(t[i].ey);
        @(posedge clk);
        #1;
        check(nm, i);
      end
    end
    bus.startOfFrame  = 1'b0;
    bus.shotHitTarget = 1'b0;
    bus.pause         = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.startOfFrame  = 1'b0;
    bus.pause         = 1'b0;
    bus.shotHitTarget = 1'b0;
    bus.enemyTopLeftX = 11'd240;
    bus.enemyTopLeftY = 11'd210;

    // launch after 91 frames, first step, fall to bottom edge
    tbl.push_back(idle(90, 1, 0, 0, 240, 210));
    tbl.push_back(idle(1, 1, 0, 0, 240, 210));
    tbl.push_back(r(1, 1, 0, 0, 240, 210, 1, 1, 254, 242, 0));
    tbl.push_back(r(1, 0, 0, 0, 240, 210, 1, 0, 254, 242, 0));
    tbl.push_back(r(1, 1, 0, 0, 240, 210, 1, 0, 254, 246, 0));
    tbl.push_back(r(53, 1, 0, 0, 240, 210, 1, 0, 254, 250, 4));
    tbl.push_back(idle(1, 1, 0, 0, 240, 210));
    // relaunch 92 frames after retirement
    tbl.push_back(idle(90, 1, 0, 0, 240, 210));
    tbl.push_back(idle(1, 1, 0, 0, 240, 210));
    tbl.push_back(r(1, 1, 0, 0, 300, 100, 1, 1, 314, 132, 0));
    tbl.push_back(r(1, 0, 0, 0, 300, 100, 1, 0, 314, 132, 0));
    tbl.push_back(r(1, 1, 0, 0, 300, 100, 1, 0, 314, 136, 0));
    // hit on a frame pulse: no step, retire, reload cooldown
    tbl.push_back(idle(1, 1, 0, 1, 300, 100));
    tbl.push_back(idle(1, 0, 0, 0, 300, 100));
    tbl.push_back(idle(90, 1, 0, 0, 300, 100));
    tbl.push_back(idle(1, 1, 0, 0, 300, 100));
    tbl.push_back(r(1, 1, 0, 0, 100, 50, 1, 1, 114, 82, 0));
    // pause freezes flight; hit while paused still retires
    tbl.push_back(r(10, 1, 1, 0, 100, 50, 1, 0, 114, 82, 0));
    tbl.push_back(r(1, 1, 0, 0, 100, 50, 1, 0, 114, 86, 0));
    tbl.push_back(idle(1, 0, 1, 1, 100, 50));
    // pause freezes cooldown; hit outside flight ignored
    tbl.push_back(idle(10, 1, 1, 1, 100, 50));
    tbl.push_back(idle(90, 1, 0, 0, 100, 50));
    tbl.push_back(idle(1, 1, 0, 0, 781, 50));
    // parked enemy never fires; unparking launches at once
    tbl.push_back(idle(200, 1, 0, 1, 781, 50));
    tbl.push_back(r(1, 1, 0, 0, 240, 210, 1, 1, 254, 242, 0));

    // after a mid-flight reset cooldown restarts from 90
    tbl2.push_back(idle(90, 1, 0, 0, 240, 210));
    tbl2.push_back(idle(1, 1, 0, 0, 240, 210));
    tbl2.push_back(r(1, 1, 0, 0, 240, 210, 1, 1, 254, 242, 0));
    tbl2.push_back(r(1, 0, 0, 0, 240, 210, 1, 0, 254, 242, 0));
    tbl2.push_back(r(1, 1, 0, 0, 240, 210, 1, 0, 254, 246, 0));

    #2;
    push_exp(1'b0, 1'b0, 2047, 2047);
    check("reset", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run("main", tbl);

    // asynchronous reset mid-cycle while the shot is in flight
    reset = 1'b1;
    #1;
    push_exp(1'b0, 1'b0, 2047, 2047);
    check("async_rst", 0);
    #2;
    reset = 1'b0;

    run("post_rst", tbl2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
